// File: rtl/slib_input_filter.sv
// -----------------------------------------------------------------------------
// slib_input_filter
//
// Purpose:
//   Cleans up an asynchronous, possibly noisy line (e.g. a UART SIN or modem
//   status input) before it reaches a downstream edge detector.
//
//   The path has three stages:
//   1. A two-flop synchronizer brings D into the CLK domain on every edge.
//   2. A saturating up/down counter integrates the synchronized level. It
//      moves only on CE (oversampling tick) edges.
//   3. The registered output Q switches with hysteresis. It goes high only
//      when the counter reaches SIZE and low only when it reaches 0.
//
//   Any excursion shorter than SIZE consecutive CE samples is therefore
//   absorbed without toggling Q.
//
// Parameters:
//   SIZE      - filter depth in enabled samples (1..255)
//   RESET_VAL - level of Q (and of the synchronizer) after reset
//
// Ports:
//   CLK   - system clock, all state updates on the rising edge
//   RST_N - synchronous active-low reset
//   CE    - sample enable; gates the counter and Q, not the synchronizer
//   D     - asynchronous raw input line
//   Q     - filtered level, driven straight from a flop
// -----------------------------------------------------------------------------
module slib_input_filter #(
  parameter int   SIZE      = 4,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic CE,
  input  logic D,
  output logic Q
);

  localparam int              CW      = $clog2(SIZE + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(SIZE);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);
  localparam logic [CW-1:0]   CNT_RST = RESET_VAL ? CNT_MAX : '0;

  logic          s1_q;
  logic          s2_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          q_q;
  logic          q_d;

  // Next-state logic for the integrator and the hysteresis output.
  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch can be inferred.
  always_comb begin
    cnt_d = cnt_q;
    q_d   = q_q;
    if (CE) begin
      if (s2_q && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_ONE;
      end else if (!s2_q && (cnt_q != '0)) begin
        cnt_d = cnt_q - CNT_ONE;
      end
      // Q is decided from the count being written this edge, so a full run
      // of SIZE samples flips the output on the same edge that completes it.
      if (cnt_d == CNT_MAX) begin
        q_d = 1'b1;
      end else if (cnt_d == '0) begin
        q_d = 1'b0;
      end
    end
  end

  // Synchronizer runs on every edge; the filter state only changes via the
  // CE-gated next-state values above. Reset is sampled with the clock, so a
  // mid-filter reset discards any partial count on that same edge.
  // NOTE: non-blocking assignments keep S1->S2 a true two-stage pipeline;
  // blocking ones here would collapse the synchronizer into one flop.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s1_q  <= RESET_VAL;
      s2_q  <= RESET_VAL;
      cnt_q <= CNT_RST;
      q_q   <= RESET_VAL;
    end else begin
      s1_q  <= D;
      s2_q  <= s1_q;
      cnt_q <= cnt_d;
      q_q   <= q_d;
    end
  end

  assign Q = q_q;

endmodule

// File: tb/tb_slib_input_filter.sv
// -----------------------------------------------------------------------------
// tb_slib_input_filter
//
// Two filter instances share one stimulus stream:
//   - u_dut4: SIZE=4 with RESET_VAL=1
//   - u_dut1: SIZE=1 with RESET_VAL=0
//
// A behavioural model predicts Q and the counter of both instances for every
// clock edge. The driver pushes each prediction into a scoreboard queue; an
// independent monitor pops the queue after each edge and compares.
//
// Directed phases reproduce these scenarios:
//   - step response
//   - glitch rejection
//   - CE gating
//   - hysteresis
//   - mid-operation reset
//   - SIZE=1 tracking
//
// A randomized phase follows them.
// -----------------------------------------------------------------------------
module tb_slib_input_filter;

  logic clk = 1'b0;
  logic rst_n;
  logic ce;
  logic d;
  logic q4;
  logic q1;

  always #5 clk = ~clk;

  slib_input_filter #(.SIZE(4), .RESET_VAL(1'b1)) u_dut4 (
    .CLK(clk), .RST_N(rst_n), .CE(ce), .D(d), .Q(q4)
  );

  slib_input_filter #(.SIZE(1), .RESET_VAL(1'b0)) u_dut1 (
    .CLK(clk), .RST_N(rst_n), .CE(ce), .D(d), .Q(q1)
  );

  // ---------------------------------------------------------------- scoreboard
  typedef struct {
    bit q4;
    int c4;
    bit q1;
    int c1;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // ----------------------------------------------------------------- the model
  // Index 0 models u_dut4, index 1 models u_dut1.
  // - The synchronizer is a plain two-sample delay line.
  // - The filter is a clamped running tally of +1 / -1 votes per enabled
  //   sample.
  // - The output changes only when the tally is pinned at either end.
  int m_size [2] = '{4, 1};
  bit m_rv   [2] = '{1'b1, 1'b0};
  bit m_s1   [2];
  bit m_s2   [2];
  int m_cnt  [2];
  bit m_q    [2];

  task automatic model_edge(input bit din, input bit cen, input bit rstn);
    for (int i = 0; i < 2; i++) begin
      if (!rstn) begin
        m_s1[i]  = m_rv[i];
        m_s2[i]  = m_rv[i];
        m_cnt[i] = m_rv[i] ? m_size[i] : 0;
        m_q[i]   = m_rv[i];
      end else begin
        if (cen) begin
          m_cnt[i] = m_s2[i] ? m_cnt[i] + 1 : m_cnt[i] - 1;
          if (m_cnt[i] > m_size[i]) m_cnt[i] = m_size[i];
          if (m_cnt[i] < 0)         m_cnt[i] = 0;
          if (m_cnt[i] == m_size[i]) m_q[i] = 1'b1;
          else if (m_cnt[i] == 0)    m_q[i] = 1'b0;
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = din;
      end
    end
  endtask

  // Apply inputs for the next rising edge and record what should follow it.
  task automatic drive(input bit din, input bit cen, input bit rstn);
    exp_t e;
    @(negedge clk);
    d     = din;
    ce    = cen;
    rst_n = rstn;
    model_edge(din, cen, rstn);
    e.q4 = m_q[0];
    e.c4 = m_cnt[0];
    e.q1 = m_q[1];
    e.c1 = m_cnt[1];
    sb.push_back(e);
  endtask

  task automatic drive_n(input bit din, input bit cen, input int n);
    for (int k = 0; k < n; k++) drive(din, cen, 1'b1);
  endtask

  // ------------------------------------------------------------------ monitor
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("q_size4",   int'(q4),                 int'(e.q4));
      check("cnt_size4", int'(u_dut4.cnt_q),       e.c4);
      check("q_size1",   int'(q1),                 int'(e.q1));
      check("cnt_size1", int'(u_dut1.cnt_q),       e.c1);
    end
  end

  // ----------------------------------------------------------------- stimulus
  initial begin
    int run;
    bit lvl;

    rst_n = 1'b0;
    ce    = 1'b0;
    d     = 1'b1;

    // Reset with CE both low and high.
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);

    // Step response: D falls before the first post-reset edge.
    drive_n(1'b0, 1'b1, 8);
    drive_n(1'b1, 1'b1, 8);

    // Glitch: three low samples, then back high.
    drive_n(1'b0, 1'b1, 3);
    drive_n(1'b1, 1'b1, 8);

    // CE gating: a tick every fourth cycle while D steps low.
    for (int k = 0; k < 28; k++) drive(1'b0, (k % 4) == 3, 1'b1);

    // Hysteresis from count 0: S2 pattern 1,1,1,0,1,1.
    drive_n(1'b0, 1'b1, 4);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    drive_n(1'b1, 1'b1, 3);

    // Reset mid-operation: drive low to 0, two high samples (count 2), reset.
    drive_n(1'b0, 1'b1, 8);
    drive_n(1'b1, 1'b1, 4);
    drive(1'b0, 1'b1, 1'b0);
    drive_n(1'b0, 1'b1, 6);

    // SIZE=1 tracking: D toggles every three cycles with CE held high.
    lvl = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (k % 3 == 0) lvl = ~lvl;
      drive(lvl, 1'b1, 1'b1);
    end

    // Randomized runs of varying length, random CE, occasional reset.
    lvl = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      if (run == 0) begin
        lvl = ~lvl;
        run = $urandom_range(1, 9);
      end
      run--;
      drive(lvl, $urandom_range(0, 3) != 0, $urandom_range(0, 199) != 0);
    end

    // Let the monitor drain, bounded.
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    #2;
    check("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/slib_input_filter.md
SLIB_INPUT_FILTER -- requirements
Module: slib_input_filter

Interface
REQ-001 SHALL provide parameter SIZE, default 4, meaning the filter depth in enabled samples (legal range 1..255).
REQ-002 SHALL provide parameter RESET_VAL, default 1'b1, meaning the idle level of the filtered line after reset (UART line idles high).
REQ-003 SHALL provide port CLK, input, 1 bit, single system clock; all state updates on its rising edge.
REQ-004 SHALL provide port RST_N, input, 1 bit, reset that is synchronous and active-low.
REQ-005 SHALL provide port CE, input, 1 bit, sample enable (oversampling tick); it gates the filter, not the synchronizer.
REQ-006 SHALL provide port D, input, 1 bit, asynchronous raw line (e.g. SIN, CTSN, DSRN, DCDN, RIN).
REQ-007 SHALL provide port Q, output, 1 bit, registered filtered level that feeds the downstream edge detector.

Function
REQ-008 SHALL pass D through a two-flop synchronizer (S1 <= D, S2 <= S1) clocked every CLK edge regardless of CE.
REQ-009 SHALL hold a saturating counter CNT of width clog2(SIZE+1), with range 0..SIZE.
REQ-010 SHALL update CNT only on edges with CE=1: S2=1 and CNT<SIZE -> CNT+1; S2=0 and CNT>0 -> CNT-1; otherwise hold.
REQ-011 SHALL hold CNT and Q unchanged on edges with CE=0.
REQ-012 SHALL drive Q from the next value of CNT on CE edges: next CNT == SIZE -> Q <= 1; next CNT == 0 -> Q <= 0; otherwise Q holds (hysteresis).
REQ-013 SHALL, with CE held at 1, make Q follow a stable D step at the (SIZE+2)th rising edge after D is first sampled by S1 (edge 1 = S1 capture).
REQ-014 SHALL reject any S2 excursion shorter than SIZE consecutive CE samples, so that Q does not toggle.
REQ-015 SHALL saturate CNT at SIZE and at 0 and never wrap, so that a long stable level costs at most SIZE samples to reverse.
REQ-016 SHALL, for SIZE=1, make Q equal S2 as sampled at the previous CE edge.
REQ-017 SHALL keep Q glitch-free, driven directly by a flop with no combinational path from D or CE to Q.

Reset
REQ-018 SHALL, on any rising CLK edge with RST_N=0, set S1=S2=RESET_VAL, CNT = (RESET_VAL ? SIZE : 0) and Q=RESET_VAL, regardless of CE and D.
REQ-019 SHALL apply reset asserted mid-filtering (CNT between 0 and SIZE) on the same edge, discarding any partial count.
REQ-020 SHALL, on the first edge with RST_N=1, resume normal operation with no extra dead cycles.

Verification
REQ-021 SHALL cover the step response: SIZE=4, RESET_VAL=1, CE=1; after reset drive D=0 before edge 1 -> Q=1 through edge 5, Q=0 at edge 6; CNT sequence 3,2,1,0 on edges 3..6.
REQ-022 SHALL cover glitch rejection: SIZE=4, Q=1 stable, CE=1; D=0 for 3 cycles then 1 -> CNT dips to 1 then returns to 4, and Q stays 1 throughout.
REQ-023 SHALL cover CE gating: SIZE=4, CE pulsed every 4th cycle, D stepped 1->0 -> CNT changes only on CE edges, and Q falls on the 4th CE edge after S2=0.
REQ-024 SHALL cover hysteresis: SIZE=4 from CNT=0, Q=0; S2 pattern 1,1,1,0,1,1 on CE edges -> CNT 1,2,3,2,3,4, and Q rises only on the final sample.
REQ-025 SHALL cover reset mid-operation: CNT=2, Q=0, RESET_VAL=1; RST_N=0 for one edge -> CNT=4, Q=1, S1=S2=1 on that edge, and normal counting on the next edge.
REQ-026 SHALL cover SIZE=1: CE=1, D toggles every 3 cycles -> Q reproduces D delayed by exactly 3 edges.
